vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator; successor to the single-axis horizontal sync counter.
//  Generates both axes: hsync, vsync, display-enable, pixel x/y, line/frame strobes and a frame count.
//  Features: per-axis porch/sync parameters, sync polarity, clock-enable gating, async reset.
//  Sits between the pixel-clock domain and the logic-analyzer trace renderer / pixel mux.
// PARAMETERS
//  H_ACTIVE  800  visible pixels per line
//  H_FP      40   horizontal front porch, pixels
//  H_SYNC    128  hsync pulse width, pixels
//  H_BP      88   horizontal back porch, pixels
//  V_ACTIVE  600  visible lines per frame
//  V_FP      1    vertical front porch, lines
//  V_SYNC    4    vsync pulse width, lines
//  V_BP      23   vertical back porch, lines
//  H_POL     1    hsync active level (1 = active-high)
//  V_POL     1    vsync active level
//  CW        11   x/y counter width; H_TOTAL-1 and V_TOTAL-1 must be < 2**CW (elaboration $error)
//  FCW       8    frame counter width
// PORTS
//  clk          in   1    pixel clock (40 MHz for defaults)
//  rst_n        in   1    asynchronous reset, active-low
//  en           in   1    pixel-step enable; counters and outputs advance only when 1
//  hsync        out  1    horizontal sync, polarity H_POL
//  vsync        out  1    vertical sync, polarity V_POL
//  display      out  1    1 when x < H_ACTIVE and y < V_ACTIVE
//  x            out  CW   current pixel column, 0..H_TOTAL-1
//  y            out  CW   current line, 0..V_TOTAL-1
//  line_start   out  1    1-cycle pulse when x == 0
//  frame_start  out  1    1-cycle pulse when x == 0 and y == 0
//  frame_cnt    out  FCW  completed-frame count, wraps
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
//  - Internal counters h, v. On en=1: h wraps at H_TOTAL-1 to 0, else h+1. v steps only on h wrap.
//    v wraps at V_TOTAL-1 to 0; frame_cnt increments on that same edge (modulo 2**FCW).
//  - All outputs registered. On each en=1 edge they capture the decode of the pre-increment h/v.
//    Result: x/y/hsync/vsync/display/strobes are mutually aligned; latency is 1 clock from counter to pins.
//  - hsync = H_POL for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~H_POL. vsync is analogous on v.
//  - en=0: counters, x, y, hsync, vsync, display and frame_cnt hold. line_start and frame_start go 0.
//    Each strobe is asserted for exactly one en cycle per event.
//  - Reset (rst_n=0, async, any time including mid-frame):
//    h=v=0, x=y=0, display=0, hsync=~H_POL, vsync=~V_POL, line_start=frame_start=0, frame_cnt=0.
//  - First en cycle after reset release gives x=0, y=0, display=1, line_start=1, frame_start=1.
//  - Comparisons are unsigned CW-bit; no value outside 0..TOTAL-1 is ever produced.
// STRUCTURE
//  - Package vga_timing_pkg: mode constants (SVGA_800x600_60, VGA_640x480_60) as parameter sets.
//    Also holds the TOTAL-calculation function and the CW sizing helper.
//  - Sub-module vga_axis_counter (instantiated twice: h, v).
//    Parameters: ACTIVE, FP, SYNC, BP, POL, CW. Inputs: clk, rst_n, step.
//    Outputs: cnt, wrap, sync, active.
//    Top level chains h.wrap&en into v.step and registers the output decode.
// TESTING
//  1. rst_n=0 with en=1 for 5 clocks -> reset values held. Release -> first edge x=0,y=0, display=1, frame_start=1.
//  2. Defaults, en=1 -> line_start period 1056 clocks; hsync=1 for exactly 128 clocks from x=840; display=0 from x=800.
//  3. Defaults, full frame -> vsync=1 on y=601..604; frame_start period 663168 clocks; frame_cnt 0->1->2.
//  4. en pattern 1,0,0,1 repeating -> same sequence as test 2 in en-cycles; outputs frozen while en=0; no repeated strobes.
//  5. Async reset pulse at x=500,y=300 -> outputs reach reset values before the next clk edge; restart at x=0,y=0.
//  6. 640x480 (16/96/48, 10/2/33), H_POL=V_POL=0 -> hsync low 96 clocks from x=656, vsync low y=490..491, 800x525 totals.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA mode parameter sets and timing helper functions
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_mode_t;

    typedef struct packed {
        axis_mode_t h;
        axis_mode_t v;
        bit         h_pol;
        bit         v_pol;
    } vga_mode_t;

    localparam vga_mode_t SVGA_800x600_60 = '{
        h: '{active: 800, fp: 40, sync: 128, bp: 88},
        v: '{active: 600, fp: 1,  sync: 4,   bp: 23},
        h_pol: 1'b1, v_pol: 1'b1
    };

    localparam vga_mode_t VGA_640x480_60 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33},
        h_pol: 1'b0, v_pol: 1'b0
    };

    function automatic int unsigned axis_total(int unsigned active, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width needed to represent 0..total-1.
    function automatic int unsigned cw_for(int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between generator and pixel consumers
interface vga_timing_gen_if #(
    parameter int unsigned CW  = 11,
    parameter int unsigned FCW = 8
);
    logic           en;
    logic           hsync;
    logic           vsync;
    logic           display;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_cnt;

    modport master (
        input  en,
        output hsync, vsync, display, x, y, line_start, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  hsync, vsync, display, x, y, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with sync/active decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FP     = 40,
    parameter int unsigned SYNC   = 128,
    parameter int unsigned BP     = 88,
    parameter bit          POL    = 1'b1,
    parameter int unsigned CW     = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          sync,
    output logic          active
);
    localparam int unsigned   TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);

    // wrap is the terminal-count flag; the caller gates it with its own step.
    assign wrap   = (cnt == LAST);
    assign sync   = (cnt >= SYNC_FIRST && cnt <= SYNC_LAST) ? POL : ~POL;
    assign active = (cnt < ACT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - two-axis VGA timing generator with registered, mutually aligned outputs
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = SVGA_800x600_60.h.active,
    parameter int unsigned H_FP     = SVGA_800x600_60.h.fp,
    parameter int unsigned H_SYNC   = SVGA_800x600_60.h.sync,
    parameter int unsigned H_BP     = SVGA_800x600_60.h.bp,
    parameter int unsigned V_ACTIVE = SVGA_800x600_60.v.active,
    parameter int unsigned V_FP     = SVGA_800x600_60.v.fp,
    parameter int unsigned V_SYNC   = SVGA_800x600_60.v.sync,
    parameter int unsigned V_BP     = SVGA_800x600_60.v.bp,
    parameter bit          H_POL    = SVGA_800x600_60.h_pol,
    parameter bit          V_POL    = SVGA_800x600_60.v_pol,
    parameter int unsigned CW       = 11,
    parameter int unsigned FCW      = 8
) (
    input logic               clk,
    input logic               rst_n,
    vga_timing_gen_if.master  vif
);
    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (CW < cw_for(H_TOTAL) || CW < cw_for(V_TOTAL)) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CW(CW)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(vif.en),
        .cnt(h_cnt), .wrap(h_wrap), .sync(h_sync), .active(h_act)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CW(CW)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(vif.en & h_wrap),
        .cnt(v_cnt), .wrap(v_wrap), .sync(v_sync), .active(v_act)
    );

    // Outputs sample the pre-increment counter decode, so every pin lags the counters by one en cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vif.x           <= '0;
            vif.y           <= '0;
            vif.display     <= 1'b0;
            vif.hsync       <= ~H_POL;
            vif.vsync       <= ~V_POL;
            vif.line_start  <= 1'b0;
            vif.frame_start <= 1'b0;
            vif.frame_cnt   <= '0;
        end else if (vif.en) begin
            vif.x           <= h_cnt;
            vif.y           <= v_cnt;
            vif.display     <= h_act & v_act;
            vif.hsync       <= h_sync;
            vif.vsync       <= v_sync;
            vif.line_start  <= (h_cnt == '0);
            vif.frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (h_wrap && v_wrap) begin
                vif.frame_cnt <= vif.frame_cnt + 1'b1;
            end
        end else begin
            vif.line_start  <= 1'b0;
            vif.frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

    typedef struct packed {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        bit hp, vp;
        int fcw;
    } cfg_t;

    typedef struct packed {
        logic        hs, vs, de, ls, fs;
        logic [15:0] x, y;
        logic [7:0]  fc;
    } exp_t;

    // Small positive-polarity raster, and 640-wide negative-polarity raster with a short frame.
    localparam cfg_t CA = '{ha: 8,   hfp: 2,  hs: 3,  hbp: 2,  va: 5,  vfp: 1, vs: 2, vbp: 1,
                            hp: 1'b1, vp: 1'b1, fcw: 2};
    localparam cfg_t CB = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 12, vfp: 2, vs: 2, vbp: 3,
                            hp: 1'b0, vp: 1'b0, fcw: 8};

    logic clk;
    logic rst_n;
    logic en;

    int checks;
    int errors;
    int k;
    bit last_en;
    exp_t qa[$];
    exp_t qb[$];

    vga_timing_gen_if #(.CW(4),  .FCW(2)) ia ();
    vga_timing_gen_if #(.CW(10), .FCW(8)) ib ();

    assign ia.en = en;
    assign ib.en = en;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4), .FCW(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .vif(ia)
    );

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(12),  .V_FP(2),  .V_SYNC(2),  .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0), .CW(10), .FCW(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .vif(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = number of enabled clock edges since reset; the visible pixel is the (k-1)th of the raster.
    function automatic exp_t model(cfg_t c, int kk, bit le);
        exp_t e;
        int ht, vt, p, px, py;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        e = '0;
        e.hs = ~c.hp;
        e.vs = ~c.vp;
        if (kk > 0) begin
            p  = kk - 1;
            px = p % ht;
            py = (p / ht) % vt;
            e.x  = 16'(px);
            e.y  = 16'(py);
            e.fc = 8'((kk / (ht * vt)) % (1 << c.fcw));
            e.de = (px < c.ha) && (py < c.va);
            e.hs = (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
            e.vs = (py >= c.va + c.vfp && py < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
            e.ls = le && (px == 0);
            e.fs = le && (px == 0) && (py == 0);
        end
        return e;
    endfunction

    function automatic exp_t sample_a();
        exp_t e;
        e = '0;
        e.hs = ia.hsync;   e.vs = ia.vsync;   e.de = ia.display;
        e.ls = ia.line_start; e.fs = ia.frame_start;
        e.x  = 16'(ia.x);  e.y  = 16'(ia.y);  e.fc = 8'(ia.frame_cnt);
        return e;
    endfunction

    function automatic exp_t sample_b();
        exp_t e;
        e = '0;
        e.hs = ib.hsync;   e.vs = ib.vsync;   e.de = ib.display;
        e.ls = ib.line_start; e.fs = ib.frame_start;
        e.x  = 16'(ib.x);  e.y  = 16'(ib.y);  e.fc = ib.frame_cnt;
        return e;
    endfunction

    task automatic check(string name, exp_t act, exp_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t act x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d req x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     name, $time, act.x, act.y, act.hs, act.vs, act.de, act.ls, act.fs, act.fc,
                     req.x, req.y, req.hs, req.vs, req.de, req.ls, req.fs, req.fc);
        end
    endtask

    // Drive one cycle of stimulus and queue what the next clock edge must produce.
    task automatic step(bit e, bit r);
        @(negedge clk);
        en = e;
        if (!r && rst_n) begin
            #1;
            rst_n = 1'b0;
            #1;
            check("async_reset_a", sample_a(), model(CA, 0, 1'b0));
            check("async_reset_b", sample_b(), model(CB, 0, 1'b0));
        end else begin
            rst_n = r;
        end
        if (!r) begin
            k = 0;
            last_en = 1'b0;
        end else begin
            if (e) k++;
            last_en = e;
        end
        qa.push_back(model(CA, k, last_en));
        qb.push_back(model(CB, k, last_en));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (qa.size() > 0) check("scb_a", sample_a(), qa.pop_front());
            if (qb.size() > 0) check("scb_b", sample_b(), qb.pop_front());
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        k       = 0;
        last_en = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b1;

        repeat (5) step(1'b1, 1'b0);
        repeat (2000) step(1'b1, 1'b1);
        for (int i = 0; i < 800; i++) step((i % 4 == 0) || (i % 4 == 3), 1'b1);
        repeat (3000) step($urandom_range(0, 3) != 0, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        repeat (31500) step(1'b1, 1'b1);
        repeat (300) step($urandom_range(0, 1) != 0, 1'b1);

        @(posedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
